// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - framebuffer single-port RAM arbiter between display reads and matrix-result writes
module fb_port_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rd_drop,
    output logic              frame_tick,
    output logic [CNT_W-1:0]  wr_stall_cnt,
    output logic [CNT_W-1:0]  rd_drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             active;
    logic             rd_grant;
    logic             wr_grant;
    logic             stall_evt;
    logic             drop_evt;
    logic             vblank_q;
    logic             vblank_rise;
    logic             rd_pend;
    logic [CNT_W-1:0] stall_live;
    logic [CNT_W-1:0] drop_live;

    // Display owns the port during active video; the writer owns it in blanking.
    always_comb begin
        active      = !hblank && !vblank;
        wr_ready    = reset_n && (active ? !rd_req : 1'b1);
        wr_grant    = wr_valid && wr_ready;
        rd_grant    = reset_n && rd_req && (active || !wr_valid);
        stall_evt   = wr_valid && !wr_ready;
        drop_evt    = reset_n && rd_req && !rd_grant;
        vblank_rise = vblank && !vblank_q;
    end

    // RAM read data is one cycle behind the registered request, so it is passed straight through.
    assign rd_data = mem_rdata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_pend   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_drop   <= 1'b0;
        end else begin
            mem_en   <= rd_grant || wr_grant;
            mem_we   <= wr_grant;
            rd_pend  <= rd_grant;
            rd_valid <= rd_pend;
            rd_drop  <= drop_evt;
            if (wr_grant) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else if (rd_grant) begin
                mem_addr <= rd_addr;
            end
        end
    end

    // Events in the vblank edge cycle belong to the new frame, so they seed the cleared counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vblank_q     <= 1'b0;
            frame_tick   <= 1'b0;
            stall_live   <= '0;
            drop_live    <= '0;
            wr_stall_cnt <= '0;
            rd_drop_cnt  <= '0;
        end else begin
            vblank_q   <= vblank;
            frame_tick <= vblank_rise;
            if (vblank_rise) begin
                wr_stall_cnt <= stall_live;
                rd_drop_cnt  <= drop_live;
                stall_live   <= {{(CNT_W-1){1'b0}}, stall_evt};
                drop_live    <= {{(CNT_W-1){1'b0}}, drop_evt};
            end else begin
                if (stall_evt && stall_live != CNT_MAX) begin
                    stall_live <= stall_live + 1'b1;
                end
                if (drop_evt && drop_live != CNT_MAX) begin
                    drop_live <= drop_live + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - directed self-checking bench for fb_port_arbiter with read-data scoreboard
module tb_fb_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        hblank;
    logic        vblank;
    logic        rd_req;
    logic [16:0] rd_addr;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        wr_valid;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        rd_drop;
    logic        frame_tick;
    logic [15:0] wr_stall_cnt;
    logic [15:0] rd_drop_cnt;

    logic        s_rd_valid;
    logic [7:0]  s_rd_data;
    logic        s_wr_ready;
    logic        s_mem_en;
    logic        s_mem_we;
    logic [16:0] s_mem_addr;
    logic [7:0]  s_mem_wdata;
    logic        s_rd_drop;
    logic        s_frame_tick;
    logic [3:0]  s_wr_stall_cnt;
    logic [3:0]  s_rd_drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    fb_port_arbiter dut (
        .clk(clk), .reset_n(reset_n), .hblank(hblank), .vblank(vblank),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rd_drop(rd_drop), .frame_tick(frame_tick),
        .wr_stall_cnt(wr_stall_cnt), .rd_drop_cnt(rd_drop_cnt)
    );

    fb_port_arbiter #(.CNT_W(4)) dut_small (
        .clk(clk), .reset_n(reset_n), .hblank(hblank), .vblank(vblank),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(s_rd_valid), .rd_data(s_rd_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(s_wr_ready),
        .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_rdata(mem_rdata), .rd_drop(s_rd_drop), .frame_tick(s_frame_tick),
        .wr_stall_cnt(s_wr_stall_cnt), .rd_drop_cnt(s_rd_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ram_f(input logic [16:0] a);
        return a[7:0] ^ {a[16:13], a[12:9]} ^ 8'h3C;
    endfunction

    // RAM model: read data appears the cycle after a read enable.
    initial mem_rdata = 8'h00;
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= ram_f(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic hb, input logic vb, input logic rq, input logic [16:0] ra,
                         input logic wv, input logic [16:0] wa, input logic [7:0] wd);
        hblank   = hb;
        vblank   = vb;
        rd_req   = rq;
        rd_addr  = ra;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
    endtask

    task automatic frame_edge(input int exp_stall, input int exp_drop);
        drive(0, 1, 0, 17'h0, 0, 17'h0, 8'h0);
        cyc();
        chk("frame_tick", frame_tick, 1);
        chk("wr_stall_cnt", wr_stall_cnt, exp_stall);
        chk("rd_drop_cnt", rd_drop_cnt, exp_drop);
        drive(0, 0, 0, 17'h0, 0, 17'h0, 8'h0);
        cyc();
        chk("frame_tick_pulse", frame_tick, 0);
    endtask

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", rd_valid, 0);
            end else begin
                chk("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 17'h0, 0, 17'h0, 8'h0);
        cyc();
        cyc();
        #1;
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_frame_tick", frame_tick, 0);

        // Active write with no read, then a read at the top address
        reset_n = 1'b1;
        drive(0, 0, 0, 17'h0, 1, 17'h00123, 8'h5C);
        #1 chk("a_wr_ready", wr_ready, 1);
        cyc();
        chk("a_mem_en", mem_en, 1);
        chk("a_mem_we", mem_we, 1);
        chk("a_mem_addr", mem_addr, 17'h00123);
        chk("a_mem_wdata", mem_wdata, 8'h5C);
        drive(0, 0, 1, 17'h1F3FF, 0, 17'h0, 8'h0);
        exp_q.push_back(ram_f(17'h1F3FF));
        #1 chk("a_rd_wr_ready", wr_ready, 0);
        cyc();
        chk("a_rd_mem_en", mem_en, 1);
        chk("a_rd_mem_we", mem_we, 0);
        chk("a_rd_mem_addr", mem_addr, 17'h1F3FF);
        chk("a_hold_wdata", mem_wdata, 8'h5C);
        drive(0, 0, 0, 17'h0, 0, 17'h0, 8'h0);
        cyc();
        chk("a_rd_valid", rd_valid, 1);
        chk("a_idle_mem_en", mem_en, 0);
        chk("a_hold_addr", mem_addr, 17'h1F3FF);
        cyc();
        chk("a_rd_valid_end", rd_valid, 0);

        // Active contention: reads win every cycle, writer stalls
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 17'h00100 + 17'(i), 1, 17'h02000 + 17'(i), 8'h11);
            exp_q.push_back(ram_f(17'h00100 + 17'(i)));
            #1 chk("b_wr_ready", wr_ready, 0);
            cyc();
            chk("b_mem_en", mem_en, 1);
            chk("b_mem_we", mem_we, 0);
            chk("b_mem_addr", mem_addr, 17'h00100 + 17'(i));
            if (i > 0) chk("b_rd_valid", rd_valid, 1);
        end
        drive(0, 0, 0, 17'h0, 0, 17'h0, 8'h0);
        cyc();
        chk("b_rd_valid_last", rd_valid, 1);
        cyc();
        chk("b_rd_valid_end", rd_valid, 0);

        // Blanking contention: write wins, read dropped
        drive(1, 0, 1, 17'h00020, 1, 17'h00010, 8'hA5);
        #1 chk("c_wr_ready", wr_ready, 1);
        cyc();
        chk("c_mem_en", mem_en, 1);
        chk("c_mem_we", mem_we, 1);
        chk("c_mem_addr", mem_addr, 17'h00010);
        chk("c_mem_wdata", mem_wdata, 8'hA5);
        chk("c_rd_drop", rd_drop, 1);
        drive(0, 0, 0, 17'h0, 0, 17'h0, 8'h0);
        cyc();
        chk("c_rd_drop_pulse", rd_drop, 0);

        frame_edge(5, 1);

        // Frame with 3 stalls and 2 drops
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 17'h00300 + 17'(i), 1, 17'h00A00, 8'h22);
            exp_q.push_back(ram_f(17'h00300 + 17'(i)));
            cyc();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 17'h00400, 1, 17'h00500 + 17'(i), 8'h22);
            cyc();
            chk("d_rd_drop", rd_drop, 1);
        end
        frame_edge(3, 2);

        // Drop in the vblank edge cycle lands in the new frame
        drive(0, 1, 1, 17'h00600, 1, 17'h00700, 8'h33);
        cyc();
        chk("e_frame_tick", frame_tick, 1);
        chk("e_stall_cnt", wr_stall_cnt, 0);
        chk("e_drop_cnt", rd_drop_cnt, 0);
        chk("e_rd_drop", rd_drop, 1);
        drive(0, 0, 0, 17'h0, 0, 17'h0, 8'h0);
        cyc();
        frame_edge(0, 1);

        // Stall saturation on the narrow-counter instance
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 1, 17'h00800 + 17'(i), 1, 17'h00B00, 8'h44);
            exp_q.push_back(ram_f(17'h00800 + 17'(i)));
            cyc();
        end
        drive(0, 0, 0, 17'h0, 0, 17'h0, 8'h0);
        cyc();
        drive(0, 1, 0, 17'h0, 0, 17'h0, 8'h0);
        cyc();
        chk("f_stall_cnt", wr_stall_cnt, 20);
        chk("f_small_stall_cnt", s_wr_stall_cnt, 15);
        chk("f_small_frame_tick", s_frame_tick, 1);
        drive(0, 0, 0, 17'h0, 0, 17'h0, 8'h0);
        cyc();
        cyc();

        // Reset one cycle after a read grant discards the read
        drive(0, 0, 1, 17'h00055, 0, 17'h0, 8'h0);
        cyc();
        chk("g_mem_en", mem_en, 1);
        reset_n = 1'b0;
        drive(0, 0, 0, 17'h0, 0, 17'h0, 8'h0);
        #1 chk("g_wr_ready", wr_ready, 0);
        cyc();
        chk("g_rd_valid", rd_valid, 0);
        chk("g_mem_en_rst", mem_en, 0);
        chk("g_mem_we_rst", mem_we, 0);
        chk("g_mem_addr_rst", mem_addr, 0);
        chk("g_mem_wdata_rst", mem_wdata, 0);
        chk("g_stall_cnt_rst", wr_stall_cnt, 0);
        chk("g_rd_drop_rst", rd_drop, 0);
        chk("g_frame_tick_rst", frame_tick, 0);
        cyc();
        reset_n = 1'b1;
        drive(0, 0, 1, 17'h00077, 0, 17'h0, 8'h0);
        exp_q.push_back(ram_f(17'h00077));
        cyc();
        chk("g_first_grant", mem_en, 1);
        chk("g_first_addr", mem_addr, 17'h00077);
        drive(0, 0, 0, 17'h0, 0, 17'h0, 8'h0);
        cyc();
        chk("g_rd_valid_after", rd_valid, 1);
        cyc();
        cyc();
        chk("q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
